// File: rtl/pc_gen_if.sv
// Fetch-side bundle for pc_gen: redirect requests in, fetch address and fault status out.
interface pc_gen_if #(
   parameter int WIDTH = 32
);
   logic             stall;
   logic             branch_en;
   logic [WIDTH-1:0] branch_target;
   logic             trap_en;
   logic [WIDTH-1:0] trap_target;
   logic             mret_en;
   logic [WIDTH-1:0] mret_target;
   logic             access_fault;
   logic [WIDTH-1:0] pc;
   logic             pc_valid;
   logic             fetch_fault;
   logic             misalign_fault;
   logic [WIDTH-1:0] fault_pc;

   modport master (
      output stall, branch_en, branch_target, trap_en, trap_target,
             mret_en, mret_target, access_fault,
      input  pc, pc_valid, fetch_fault, misalign_fault, fault_pc
   );

   modport slave (
      input  stall, branch_en, branch_target, trap_en, trap_target,
             mret_en, mret_target, access_fault,
      output pc, pc_valid, fetch_fault, misalign_fault, fault_pc
   );
endinterface

// File: rtl/pc_gen.sv
// Program counter generator: BOOT/RUN/FAULT FSM, one-cycle redirect (trap > mret > branch > fault > stall > +4).
// stall holds pc; PC_GEN_MISALIGN_CHECK_EN turns misaligned branch targets into a latched fault.
module pc_gen #(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_ADDR = 32'h0000_0000
) (
   input  logic    clk,
   input  logic    rst_n,
   pc_gen_if.slave bus
);
   typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

   localparam logic [WIDTH-1:0] RST_PC = {RESET_ADDR[WIDTH-1:2], 2'b00};

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic             fetch_fault_q, fetch_fault_d;
   logic [WIDTH-1:0] fault_pc_q, fault_pc_d;
   logic [WIDTH-1:0] trap_pc, mret_pc, branch_pc;
   logic             unused_lsbs;

   assign trap_pc     = {bus.trap_target[WIDTH-1:2], 2'b00};
   assign mret_pc     = {bus.mret_target[WIDTH-1:2], 2'b00};
   assign branch_pc   = {bus.branch_target[WIDTH-1:2], 2'b00};
   assign unused_lsbs = ^{bus.trap_target[1:0], bus.mret_target[1:0], bus.branch_target[1:0]};

`ifdef PC_GEN_MISALIGN_CHECK_EN
   logic misalign_fault_q, misalign_fault_d;
   logic branch_misaligned;
   assign branch_misaligned = |bus.branch_target[1:0];
`endif

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      fetch_fault_d = fetch_fault_q;
      fault_pc_d    = fault_pc_q;
`ifdef PC_GEN_MISALIGN_CHECK_EN
      misalign_fault_d = misalign_fault_q;
`endif
      case (state_q)
         BOOT: begin
            state_d = RUN;
            if (bus.trap_en) pc_d = trap_pc;
         end
         RUN: begin
            if (bus.trap_en) begin
               pc_d = trap_pc;
            end else if (bus.mret_en) begin
               pc_d = mret_pc;
            end else if (bus.branch_en) begin
`ifdef PC_GEN_MISALIGN_CHECK_EN
               if (branch_misaligned) begin
                  misalign_fault_d = 1'b1;
                  fault_pc_d       = bus.branch_target;
                  state_d          = FAULT;
               end else begin
                  pc_d = branch_pc;
               end
`else
               pc_d = branch_pc;
`endif
            end else if (bus.access_fault) begin
               fetch_fault_d = 1'b1;
               fault_pc_d    = pc_q;
               state_d       = FAULT;
            end else if (!bus.stall) begin
               pc_d = pc_q + WIDTH'(4);
            end
         end
         FAULT: begin
            // Only a trap leaves FAULT; every other request is dropped.
            if (bus.trap_en) begin
               pc_d          = trap_pc;
               fetch_fault_d = 1'b0;
`ifdef PC_GEN_MISALIGN_CHECK_EN
               misalign_fault_d = 1'b0;
`endif
               state_d       = RUN;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= BOOT;
         pc_q          <= RST_PC;
         fetch_fault_q <= 1'b0;
         fault_pc_q    <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         fetch_fault_q <= fetch_fault_d;
         fault_pc_q    <= fault_pc_d;
      end
   end

`ifdef PC_GEN_MISALIGN_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) misalign_fault_q <= 1'b0;
      else        misalign_fault_q <= misalign_fault_d;
   end
   assign bus.misalign_fault = misalign_fault_q;
`else
   assign bus.misalign_fault = 1'b0;
`endif

   assign bus.pc          = pc_q;
   assign bus.pc_valid    = (state_q == RUN);
   assign bus.fetch_fault = fetch_fault_q;
   assign bus.fault_pc    = fault_pc_q;
endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: boot sequence, redirects, faults, wrap, reset mid-fault.
module tb_pc_gen;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   pc_gen_if #(.WIDTH(32)) bus ();

   pc_gen #(.WIDTH(32), .RESET_ADDR(32'h0000_0000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.stall         = 1'b0;
      bus.branch_en     = 1'b0;
      bus.branch_target = '0;
      bus.trap_en       = 1'b0;
      bus.trap_target   = '0;
      bus.mret_en       = 1'b0;
      bus.mret_target   = '0;
      bus.access_fault  = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc", bus.pc, 32'h0);
      chk("rst_valid", 32'(bus.pc_valid), 32'h0);
      chk("rst_ff", 32'(bus.fetch_fault), 32'h0);
      chk("rst_mf", 32'(bus.misalign_fault), 32'h0);
      chk("rst_fpc", bus.fault_pc, 32'h0);

      // Boot sequence: BOOT at 0, then 0 valid, 4, 8, 12, 16
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("boot_pc", bus.pc, 32'h0);
      chk("boot_valid", 32'(bus.pc_valid), 32'h0);
      step();
      chk("run0_pc", bus.pc, 32'h0);
      chk("run0_valid", 32'(bus.pc_valid), 32'h1);
      step(); chk("seq4", bus.pc, 32'h4);
      step(); chk("seq8", bus.pc, 32'h8);
      step(); chk("seq12", bus.pc, 32'hC);
      step(); chk("seq16", bus.pc, 32'h10);

      // Branch then stall
      bus.branch_en = 1'b1; bus.branch_target = 32'h200;
      step(); chk("br_200", bus.pc, 32'h200);
      idle();
      step(); chk("pc_204", bus.pc, 32'h204);
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(); chk("stall_hold", bus.pc, 32'h204);
      end
      bus.stall = 1'b0;
      step(); chk("stall_rel", bus.pc, 32'h208);

      // Simultaneous trap/mret/branch: trap wins; then mret alone
      bus.trap_en = 1'b1;   bus.trap_target = 32'h100;
      bus.mret_en = 1'b1;   bus.mret_target = 32'h80;
      bus.branch_en = 1'b1; bus.branch_target = 32'h300;
      step(); chk("prio_trap", bus.pc, 32'h100);
      idle();
      bus.mret_en = 1'b1; bus.mret_target = 32'h80;
      step(); chk("mret_80", bus.pc, 32'h80);
      idle();

      // Access fault at 0x40, ignored requests, trap exit
      bus.branch_en = 1'b1; bus.branch_target = 32'h40;
      step(); chk("br_40", bus.pc, 32'h40);
      idle();
      bus.access_fault = 1'b1;
      step();
      chk("af_pc", bus.pc, 32'h40);
      chk("af_ff", 32'(bus.fetch_fault), 32'h1);
      chk("af_fpc", bus.fault_pc, 32'h40);
      chk("af_valid", 32'(bus.pc_valid), 32'h0);
      idle();
      bus.branch_en = 1'b1; bus.branch_target = 32'h300;
      bus.mret_en = 1'b1; bus.mret_target = 32'h80;
      step();
      chk("flt_ign_pc", bus.pc, 32'h40);
      chk("flt_ign_ff", 32'(bus.fetch_fault), 32'h1);
      idle();
      bus.trap_en = 1'b1; bus.trap_target = 32'h100;
      step();
      chk("flt_exit_pc", bus.pc, 32'h100);
      chk("flt_exit_ff", 32'(bus.fetch_fault), 32'h0);
      chk("flt_exit_valid", 32'(bus.pc_valid), 32'h1);
      idle();

      // Trap beats access fault; low target bits masked
      bus.trap_en = 1'b1; bus.trap_target = 32'h123; bus.access_fault = 1'b1;
      step();
      chk("trap_af_pc", bus.pc, 32'h120);
      chk("trap_af_ff", 32'(bus.fetch_fault), 32'h0);
      chk("trap_af_valid", 32'(bus.pc_valid), 32'h1);
      idle();

      // Wrap at top of address space
      bus.branch_en = 1'b1; bus.branch_target = 32'hFFFF_FFFC;
      step(); chk("br_top", bus.pc, 32'hFFFF_FFFC);
      idle();
      step();
      chk("wrap_pc", bus.pc, 32'h0);
      chk("wrap_ff", 32'(bus.fetch_fault), 32'h0);
      chk("wrap_valid", 32'(bus.pc_valid), 32'h1);

      // Misaligned branch target
      bus.branch_en = 1'b1; bus.branch_target = 32'h202;
      step();
      idle();
`ifdef PC_GEN_MISALIGN_CHECK_EN
      chk("mis_pc", bus.pc, 32'h0);
      chk("mis_mf", 32'(bus.misalign_fault), 32'h1);
      chk("mis_fpc", bus.fault_pc, 32'h202);
      chk("mis_valid", 32'(bus.pc_valid), 32'h0);
`else
      chk("mis_pc", bus.pc, 32'h200);
      chk("mis_mf", 32'(bus.misalign_fault), 32'h0);
      chk("mis_valid", 32'(bus.pc_valid), 32'h1);
      bus.access_fault = 1'b1;
      step();
      idle();
      chk("af2_ff", 32'(bus.fetch_fault), 32'h1);
      chk("af2_valid", 32'(bus.pc_valid), 32'h0);
`endif

      // Asynchronous reset in FAULT
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_pc", bus.pc, 32'h0);
      chk("arst_valid", 32'(bus.pc_valid), 32'h0);
      chk("arst_ff", 32'(bus.fetch_fault), 32'h0);
      chk("arst_mf", 32'(bus.misalign_fault), 32'h0);
      chk("arst_fpc", bus.fault_pc, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reboot_valid", 32'(bus.pc_valid), 32'h0);
      step();
      chk("reboot_pc", bus.pc, 32'h0);
      chk("reboot_valid1", 32'(bus.pc_valid), 32'h1);
      step();
      chk("reboot_pc4", bus.pc, 32'h4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath and PC width.
REQ-002 SHALL have parameter RESET_ADDR, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port stall  input  1  hold current PC (downstream not ready).
REQ-006 SHALL have port branch_en  input  1  taken branch/jump this cycle.
REQ-007 SHALL have port branch_target  input  WIDTH  branch/jump destination.
REQ-008 SHALL have port trap_en  input  1  trap redirect request.
REQ-009 SHALL have port trap_target  input  WIDTH  trap vector (mtvec).
REQ-010 SHALL have port mret_en  input  1  return-from-trap request.
REQ-011 SHALL have port mret_target  input  WIDTH  return address (mepc).
REQ-012 SHALL have port access_fault  input  1  fault flag from fetch stage for current pc.
REQ-013 SHALL have port pc  output  WIDTH  address presented to fetch stage.
REQ-014 SHALL have port pc_valid  output  1  pc holds a fetchable address.
REQ-015 SHALL have port fetch_fault  output  1  access fault latched, trap pending.
REQ-016 SHALL have port misalign_fault  output  1  misaligned branch target latched.
REQ-017 SHALL have port fault_pc  output  WIDTH  address that caused the latched fault.

Function
REQ-018 SHALL implement FSM states BOOT, RUN, FAULT.
REQ-019 BOOT: pc=RESET_ADDR, pc_valid=0; SHALL go to RUN on the next edge unconditionally, pc unchanged.
REQ-020 RUN: pc_valid=1; next pc chosen by priority trap_en > mret_en > branch_en > access_fault > stall > pc+4.
REQ-021 trap_en SHALL load trap_target with bits [1:0] forced to 0, in any state.
REQ-022 mret_en SHALL load mret_target with bits [1:0] forced to 0 (RUN only).
REQ-023 access_fault in RUN (no higher-priority redirect) SHALL hold pc, set fetch_fault, capture fault_pc=pc, enter FAULT.
REQ-024 FAULT: pc held, pc_valid=0, fetch_fault/misalign_fault held; stall, branch_en, mret_en, access_fault ignored; only trap_en exits (to RUN, flags cleared).
REQ-025 pc+4 SHALL wrap modulo 2^WIDTH (32'hFFFF_FFFC -> 32'h0000_0000), no fault raised.
REQ-026 Redirect latency SHALL be one cycle: request sampled at edge N, new pc visible after edge N.
REQ-027 trap_en in RUN with access_fault high SHALL take the trap; no fault latched.
REQ-028 pc[1:0] SHALL always be 2'b00.

Reset
REQ-029 rst_n low SHALL asynchronously force state=BOOT, pc=RESET_ADDR, pc_valid=0, fetch_fault=0, misalign_fault=0, fault_pc=0.
REQ-030 Reset asserted mid-operation (any state, any pending request) SHALL discard all state; release restarts at BOOT.

Configuration
REQ-031 Macro PC_GEN_MISALIGN_CHECK_EN SHALL select target alignment checking.
REQ-032 Defined: branch_en with branch_target[1:0]!=0 in RUN (no trap/mret) SHALL not redirect; pc held, misalign_fault=1, fault_pc=branch_target, enter FAULT.
REQ-033 Undefined: branch_target[1:0] SHALL be forced to 0 and taken normally; misalign_fault tied 0.

Verification
REQ-034 Reset release, no requests -> cycle 0 pc=0 pc_valid=0; then pc=0 (valid), 4, 8, 12 on successive edges.
REQ-035 pc=0x10, branch_en=1 target 0x200 -> next pc=0x200; stall=1 for 3 cycles -> pc stays 0x204 until stall drops.
REQ-036 pc=0x40, access_fault=1 -> pc holds 0x40, fetch_fault=1, fault_pc=0x40, pc_valid=0; branch_en ignored; trap_en with trap_target 0x100 -> pc=0x100, fetch_fault=0.
REQ-037 Same cycle trap_en (0x100), mret_en (0x80), branch_en (0x300) -> pc=0x100; next cycle mret_en only -> pc=0x80.
REQ-038 pc=0xFFFF_FFFC, no requests -> pc=0x0000_0000, no fault; rst_n pulsed low mid-FAULT -> pc=RESET_ADDR immediately, flags cleared.
REQ-039 Branch to 0x202: with PC_GEN_MISALIGN_CHECK_EN -> misalign_fault=1, fault_pc=0x202, pc held; without -> pc=0x200, misalign_fault=0.
